// File: rtl/disparity_packer.sv
// Packs 2-bit disparity samples four to a byte, tags line/frame starts,
// and buffers the bytes in a small FIFO for a valid/ready byte consumer.
module disparity_packer #(
  parameter int LINE_WIDTH = 16,
  parameter int NUM_LINES  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       pxclk,
  input  logic       reset,
  input  logic [1:0] disparity,
  input  logic       valid,
  output logic [7:0] out_data,
  output logic       out_sol,
  output logic       out_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int PW = $clog2(LINE_WIDTH);
  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [PW-1:0] PIX_LAST = PW'(LINE_WIDTH - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(NUM_LINES - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic [5:0]    pack;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [9:0]    head;
  logic [9:0]    push_word;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          sol_b;
  logic          sof_b;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push_req = valid && (pix_cnt[1:0] == 2'd3);
  assign pop      = !empty && out_ready;
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);

  // The byte completing at pix_cnt==3 is the one that started at pixel 0.
  assign sol_b     = (pix_cnt == PW'(3));
  assign sof_b     = sol_b && (line_cnt == '0);
  assign push_word = {sof_b, sol_b, disparity, pack};

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : head[7:0];
  assign out_sol   = empty ? 1'b0 : head[8];
  assign out_sof   = empty ? 1'b0 : head[9];

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      pack     <= '0;
    end else if (valid) begin
      if (pix_cnt[1:0] != 2'd3)
        pack[{pix_cnt[1:0], 1'b0} +: 2] <= disparity;
      if (pix_cnt == PIX_LAST) begin
        pix_cnt  <= '0;
        line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + LW'(1);
      end else begin
        pix_cnt <= pix_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && !push)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge pxclk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= push_word;
  end

endmodule

// File: tb/tb_disparity_packer.sv
// Directed bench for disparity_packer: packing, markers, FIFO stall,
// overflow, simultaneous push/pop and mid-group reset.
module tb_disparity_packer;

  logic       pxclk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] disparity = 2'd0;
  logic       valid = 1'b0;
  logic [7:0] out_data;
  logic       out_sol;
  logic       out_sof;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  logic [9:0] q [$];

  disparity_packer #(
    .LINE_WIDTH(16),
    .NUM_LINES(16),
    .FIFO_DEPTH(8)
  ) dut (
    .pxclk(pxclk),
    .reset(reset),
    .disparity(disparity),
    .valid(valid),
    .out_data(out_data),
    .out_sol(out_sol),
    .out_sof(out_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 pxclk = ~pxclk;

  // Inputs change 1 time unit after posedge, so negedge sees the
  // handshake that the next posedge will act on.
  always @(negedge pxclk)
    if (!reset && out_valid && out_ready)
      q.push_back({out_sof, out_sol, out_data});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] d, input logic v);
    disparity = d;
    valid = v;
    @(posedge pxclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, 1'b0);
  endtask

  task automatic feed_byte(input logic [7:0] b);
    for (int j = 0; j < 4; j++) step(b[2*j +: 2], 1'b1);
  endtask

  task automatic do_reset();
    valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge pxclk);
    @(posedge pxclk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  int bad;
  logic [9:0] exp_w;

  initial begin
    // reset state
    @(posedge pxclk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", overflow, 0);
    do_reset();

    // basic packing and latency
    out_ready = 1'b1;
    step(2'd0, 1'b1);
    step(2'd1, 1'b1);
    step(2'd2, 1'b1);
    chk("lat_pre", out_valid, 0);
    step(2'd3, 1'b1);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'hE4);
    chk("lat_sof", {out_sof, out_sol}, 2'b11);
    for (int i = 4; i < 16; i++) step(2'(i % 4), 1'b1);
    idle(3);
    chk("basic_cnt", q.size(), 4);
    chk("basic_b0", q[0], {2'b11, 8'hE4});
    chk("basic_b1", q[1], {2'b00, 8'hE4});
    chk("basic_b3", q[3], {2'b00, 8'hE4});
    q.delete();

    // gapped input: line 1, value 3
    for (int i = 0; i < 16; i++) begin
      step(2'd3, 1'b1);
      step(2'd0, 1'b0);
    end
    idle(3);
    chk("gap_cnt", q.size(), 4);
    chk("gap_b0", q[0], {2'b01, 8'hFF});
    chk("gap_b2", q[2], {2'b00, 8'hFF});

    // full frame plus 4 samples
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) step(2'(i % 4), 1'b1);
    idle(3);
    chk("frame_cnt", q.size(), 65);
    bad = 0;
    for (int b = 0; b < q.size(); b++) begin
      exp_w[7:0] = 8'hE4;
      exp_w[8] = (b % 4 == 0);
      exp_w[9] = (b % 4 == 0) && ((b / 4) % 16 == 0);
      if (q[b] !== exp_w) bad++;
    end
    chk("frame_marks", bad, 0);
    chk("frame_wrap", q[64], {2'b11, 8'hE4});

    // stall, overflow, drain
    do_reset();
    for (int k = 0; k < 8; k++) feed_byte(8'(8'hA0 + k));
    chk("stall_full_ovf", overflow, 0);
    feed_byte(8'hA8);
    chk("stall_ovf_set", overflow, 1);
    feed_byte(8'hA9);
    chk("stall_head", {out_sof, out_sol, out_data}, {2'b11, 8'hA0});
    idle(5);
    chk("stall_hold", {out_valid, out_data}, {1'b1, 8'hA0});
    chk("stall_sticky", overflow, 1);
    out_ready = 1'b1;
    idle(10);
    chk("drain_cnt", q.size(), 8);
    bad = 0;
    for (int b = 0; b < q.size(); b++) begin
      exp_w[7:0] = 8'(8'hA0 + b);
      exp_w[8] = (b % 4 == 0);
      exp_w[9] = (b == 0);
      if (q[b] !== exp_w) bad++;
    end
    chk("drain_order", bad, 0);
    chk("drain_sticky", overflow, 1);
    q.delete();
    for (int i = 0; i < 24; i++) step(2'd1, 1'b1);
    idle(3);
    chk("align_cnt", q.size(), 6);
    chk("align_b0", q[0], {2'b00, 8'h55});
    chk("align_b2", q[2], {2'b01, 8'h55});

    // full FIFO with push and pop on one edge
    do_reset();
    for (int k = 0; k < 8; k++) feed_byte(8'hAA);
    step(2'd1, 1'b1);
    step(2'd1, 1'b1);
    step(2'd1, 1'b1);
    out_ready = 1'b1;
    step(2'd1, 1'b1);
    out_ready = 1'b0;
    chk("pp_ovf", overflow, 0);
    chk("pp_valid", out_valid, 1);
    out_ready = 1'b1;
    idle(12);
    chk("pp_cnt", q.size(), 9);
    chk("pp_last", q[8], {2'b01, 8'h55});
    chk("pp_ovf_end", overflow, 0);

    // reset in mid-group with a byte buffered
    do_reset();
    feed_byte(8'hFF);
    step(2'd2, 1'b1);
    step(2'd2, 1'b1);
    reset = 1'b1;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", {out_sof, out_sol, out_data}, 10'd0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge pxclk);
    #1;
    reset = 1'b0;
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(2'd1, 1'b1);
    idle(3);
    chk("mid_cnt", q.size(), 1);
    chk("mid_byte", q[0], {2'b11, 8'h55});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
